// File: rtl/pps_frequency_synth.sv
// PPS-committed NCO square-wave synthesizer on the PicoBlaze port bus.
// Optional macro PPS_PHASE_ALIGN_EN: clear the phase accumulator on every PPS edge while enabled.
module pps_frequency_synth #(
  parameter logic [7:0] BASE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pps,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] in_port,
  input  logic       read_strobe,
  output logic       out,
  output logic       tick
);

  localparam logic [7:0] ADDR_TW0  = BASE;
  localparam logic [7:0] ADDR_TW1  = BASE + 8'd1;
  localparam logic [7:0] ADDR_TW2  = BASE + 8'd2;
  localparam logic [7:0] ADDR_TW3  = BASE + 8'd3;
  localparam logic [7:0] ADDR_CTRL = BASE + 8'd4;
  localparam logic [7:0] ADDR_STAT = BASE + 8'd5;

  logic [31:0] stage_q, stage_d;
  logic [31:0] tw_q, tw_d;
  logic [31:0] acc_q, acc_d;
  logic        en_q, en_d;
  logic        imm_q, imm_d;
  logic        pending_q, pending_d;
  logic        p1_q, p2_q, pps_dly_q;
  logic        out_q, out_d;
  logic        tick_q, tick_d;

  logic        pps_edge;
  logic        commit;
  logic        wr_ctrl;
  logic [32:0] sum;
  logic        rd_hit;
  logic [7:0]  rd_data;

  // Reads have no side effects; the strobe is intentionally ignored.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  assign pps_edge = p2_q & ~pps_dly_q;
  // pending_q is the registered request, so a request raised during an edge waits for the next one.
  assign commit   = pending_q & (imm_q | pps_edge);
  assign wr_ctrl  = write_strobe & (port_id == ADDR_CTRL);

  always_comb begin
    stage_d = stage_q;
    if (write_strobe) begin
      case (port_id)
        ADDR_TW0: stage_d[31:24] = out_port;
        ADDR_TW1: stage_d[23:16] = out_port;
        ADDR_TW2: stage_d[15:8]  = out_port;
        ADDR_TW3: stage_d[7:0]   = out_port;
        default:  ;
      endcase
    end
  end

  always_comb begin
    en_d      = en_q;
    imm_d     = imm_q;
    pending_d = pending_q;
    tw_d      = tw_q;
    if (commit) begin
      tw_d      = stage_q;
      pending_d = 1'b0;
    end
    if (wr_ctrl) begin
      en_d  = out_port[0];
      imm_d = out_port[1];
      if (out_port[2]) pending_d = 1'b1;
    end
  end

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, tw_q};
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (en_q) begin
      acc_d  = sum[31:0];
      tick_d = sum[32];
    end
`ifdef PPS_PHASE_ALIGN_EN
    if (en_q && pps_edge) begin
      acc_d  = '0;
      tick_d = 1'b0;
    end
`endif
    out_d = acc_d[31];
  end

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    case (port_id)
      ADDR_TW0:  rd_data = tw_q[31:24];
      ADDR_TW1:  rd_data = tw_q[23:16];
      ADDR_TW2:  rd_data = tw_q[15:8];
      ADDR_TW3:  rd_data = tw_q[7:0];
      ADDR_CTRL: rd_data = {5'b0, pending_q, imm_q, en_q};
      ADDR_STAT: rd_data = {6'b0, out_q, pending_q};
      default:   rd_hit  = 1'b0;
    endcase
  end

  assign in_port = rd_hit ? rd_data : 'z;
  assign out     = out_q;
  assign tick    = tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q   <= '0;
      tw_q      <= '0;
      acc_q     <= '0;
      en_q      <= 1'b0;
      imm_q     <= 1'b0;
      pending_q <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      pps_dly_q <= 1'b0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      tw_q      <= tw_d;
      acc_q     <= acc_d;
      en_q      <= en_d;
      imm_q     <= imm_d;
      pending_q <= pending_d;
      p1_q      <= pps;
      p2_q      <= p1_q;
      pps_dly_q <= p2_q;
      out_q     <= out_d;
      tick_q    <= tick_d;
    end
  end

endmodule
